// File: rtl/vend_change_display.sv
// Vending-machine change/display block: compares money against price, shows both as
// two-digit active-low 7-segment values, and latches change digits plus a sale flag on commit.
module vend_change_display #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] money,
  input  logic [WIDTH-1:0] price,
  input  logic             commit,
  input  logic             clear,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [6:0]       money_ones,
  output logic [6:0]       money_tens,
  output logic [6:0]       price_ones,
  output logic [6:0]       price_tens,
  output logic [6:0]       change_ones,
  output logic [6:0]       change_tens,
  output logic             sale_ok
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Shift-add-3 conversion; two BCD digits cover values up to 31.
  function automatic logic [7:0] bin2bcd(input logic [WIDTH-1:0] v);
    logic [7:0] bcd;
    bcd = 8'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
      bcd = {bcd[6:0], v[i]};
    end
    return bcd;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0] change;
  logic [7:0]       money_bcd;
  logic [7:0]       price_bcd;
  logic [7:0]       change_bcd;
  logic [6:0]       change_ones_dec;
  logic [6:0]       change_tens_dec;

  assign eq = (money == price);
  assign lt = (money < price);
  assign gt = (money > price);

  // Two's-complement subtract; carry-out dropped, result only used when money >= price.
  assign change = money + ~price + {{(WIDTH-1){1'b0}}, 1'b1};

  assign money_bcd  = bin2bcd(money);
  assign price_bcd  = bin2bcd(price);
  assign change_bcd = bin2bcd(change);

  assign money_ones      = (money == '0) ? SEG_BLANK : seg7(money_bcd[3:0]);
  assign money_tens      = (money == '0) ? SEG_BLANK : seg7(money_bcd[7:4]);
  assign price_ones      = seg7(price_bcd[3:0]);
  assign price_tens      = seg7(price_bcd[7:4]);
  assign change_ones_dec = seg7(change_bcd[3:0]);
  assign change_tens_dec = seg7(change_bcd[7:4]);

  // Register stage: reset > clear > commit > hold.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      change_ones <= SEG_BLANK;
      change_tens <= SEG_BLANK;
      sale_ok     <= 1'b0;
    end else if (commit) begin
      if (lt) begin
        change_ones <= SEG_BLANK;
        change_tens <= SEG_BLANK;
        sale_ok     <= 1'b0;
      end else begin
        change_ones <= change_ones_dec;
        change_tens <= change_tens_dec;
        sale_ok     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vend_change_display.sv
// Self-checking bench for vend_change_display: directed steps then randomized traffic
// against an arithmetic reference model (subtract, divide by ten, digit table).
module tb_vend_change_display;

  logic       clk = 1'b0;
  logic       reset, commit, clear;
  logic [4:0] money, price;
  logic       eq, lt, gt, sale_ok;
  logic [6:0] money_ones, money_tens, price_ones, price_tens, change_ones, change_tens;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [0:9];
  logic [6:0] exp_co, exp_ct;
  logic       exp_ok;

  vend_change_display #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .money(money), .price(price),
    .commit(commit), .clear(clear), .eq(eq), .lt(lt), .gt(gt),
    .money_ones(money_ones), .money_tens(money_tens),
    .price_ones(price_ones), .price_tens(price_tens),
    .change_ones(change_ones), .change_tens(change_tens), .sale_ok(sale_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check combinational outputs, clock, update model, check registers.
  task automatic step(input int m, input int p, input logic c, input logic cl, input logic r);
    int chg;
    logic [6:0] mt, mo;
    @(negedge clk);
    money = 5'(m); price = 5'(p); commit = c; clear = cl; reset = r;
    #1;
    check("cmp", {13'd0, eq, lt, gt}, {13'd0, m == p, m < p, m > p});
    mt = (m == 0) ? 7'h7f : seg_tab[m / 10];
    mo = (m == 0) ? 7'h7f : seg_tab[m % 10];
    check("money_seg", {2'b0, money_tens, money_ones}, {2'b0, mt, mo});
    check("price_seg", {2'b0, price_tens, price_ones}, {2'b0, seg_tab[p / 10], seg_tab[p % 10]});
    @(posedge clk);
    if (r || cl) begin
      exp_ct = 7'h7f; exp_co = 7'h7f; exp_ok = 1'b0;
    end else if (c) begin
      if (m < p) begin
        exp_ct = 7'h7f; exp_co = 7'h7f; exp_ok = 1'b0;
      end else begin
        chg = m - p;
        exp_ct = seg_tab[chg / 10]; exp_co = seg_tab[chg % 10]; exp_ok = 1'b1;
      end
    end
    #1;
    check("change_reg", {1'b0, change_tens, change_ones, sale_ok}, {1'b0, exp_ct, exp_co, exp_ok});
    commit = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    exp_co = 7'h7f; exp_ct = 7'h7f; exp_ok = 1'b0;
    reset = 1'b1; commit = 1'b0; clear = 1'b0; money = '0; price = '0;

    step(0, 10, 0, 0, 1);
    check("reset_literal", {1'b0, change_tens, change_ones, sale_ok}, {1'b0, 7'b1111111, 7'b1111111, 1'b0});
    step(0, 10, 0, 0, 0);
    step(13, 5, 1, 0, 0);
    check("chg_08_literal", {1'b0, change_tens, change_ones, sale_ok}, {1'b0, 7'b1000000, 7'b0000000, 1'b1});
    step(31, 1, 1, 0, 0);
    step(2, 1, 0, 0, 0);
    check("hold_30_literal", {2'b0, change_tens, change_ones}, {2'b0, 7'b0110000, 7'b1000000});
    step(3, 5, 1, 0, 0);
    step(5, 5, 1, 0, 0);
    step(5, 5, 0, 1, 0);
    step(20, 4, 1, 0, 0);
    step(20, 4, 1, 1, 0);
    step(20, 4, 1, 0, 0);
    step(20, 4, 1, 0, 1);
    step(31, 31, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 31, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_change_display.md
Name: vend_change_display

Overview:
- Compares a 5-bit inserted-money value against a 5-bit product price and computes the change.
- Converts money, price and change to two-digit BCD and drives six active-low 7-segment digits.
- Change digits and a sale-OK flag are latched on a commit strobe.
- Sits between the switch/key front-end and the HEX/LED outputs of the vending-machine top level.

Parameters:
- WIDTH, 5, binary width of money/price/change; BCD path sized for max value 2^WIDTH-1 = 31, two digits.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all registered outputs
- money  input  WIDTH  inserted amount, unsigned binary
- price  input  WIDTH  selected product price, unsigned binary
- commit  input  1  one-cycle purchase strobe, already synchronised and edge-detected upstream
- clear  input  1  one-cycle strobe; blanks latched change display
- eq  output  1  combinational, money == price
- lt  output  1  combinational, money < price
- gt  output  1  combinational, money > price
- money_ones, money_tens  output  7 each  active-low segments of money; blank when money == 0
- price_ones, price_tens  output  7 each  active-low segments of price; always shown
- change_ones, change_tens  output  7 each  registered active-low segments of change
- sale_ok  output  1  registered; 1 after a commit with money >= price

Behaviour:
- Segment bit order: [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g. Active-low: 0 = lit.
- Digit codes, active-low, [6:0]:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - BCD 10..15 = 1111111 (blank; unreachable for WIDTH=5)
- Binary-to-BCD: combinational, value 0..31 split into tens (0..3) and ones (0..9). Implemented as double-dabble (shift-add-3); no divider.
- Compare: combinational unsigned magnitude compare. Exactly one of eq/lt/gt is high at all times.
- Change arithmetic:
  - change = money + ~price + 1, truncated to WIDTH bits (two's-complement subtract).
  - Only meaningful when lt = 0; carry-out discarded.
- Combinational displays:
  - Money digits forced to 1111111 when money == 0. Value 0 is never shown as "00" on the money display.
  - Price digits are always decoded, including "00" for price 0.
- Registered path, priority reset > clear > commit:
  - reset = 1 at edge: change_ones = change_tens = 1111111, sale_ok = 0.
  - clear = 1 at edge (no reset): same values as reset.
  - commit = 1 at edge, lt = 0: change digits load the decoded change, sale_ok = 1.
  - commit = 1 at edge, lt = 1: change digits load 1111111, sale_ok = 0.
  - Otherwise: hold.
- Latency: combinational outputs follow inputs with zero cycles. Registered outputs update at the clock edge that samples commit, and are visible the cycle after the strobe.
- Change display holds its latched value while money/price change after commit.
- Simultaneous commit and clear: clear wins.
- Simultaneous commit and reset: reset wins.
- Power-up before first reset: registered outputs undefined. The top level must assert reset at start-up.
- Module ordering inside: comparator, subtractor, three BCD converters, six segment decoders, one register stage (15 flops).

Test Plan:
- reset = 1 one cycle → change_ones = change_tens = 1111111, sale_ok = 0. Then money = 0, price = 10 → money digits 1111111/1111111; price_tens = 1111001, price_ones = 1000000; lt = 1.
- money = 13, price = 5, commit pulse → gt = 1. Next cycle: change_tens = 1000000, change_ones = 0000000 ("08"), sale_ok = 1. Money shows "13": tens 1111001, ones 0110000.
- money = 31, price = 1, commit → change "30": tens 0110000, ones 1000000, sale_ok = 1. Then change money to 2 without commit → change digits hold "30".
- money = 3, price = 5, commit → lt = 1. Next cycle: change digits 1111111, sale_ok = 0.
- money = 5, price = 5, commit → eq = 1. Change "00": both digits 1000000, sale_ok = 1. Then clear pulse → blank, sale_ok = 0.
- After a valid sale, commit and clear asserted in the same cycle → blank, sale_ok = 0. Repeat with reset plus commit → blank, sale_ok = 0.
